// File: rtl/timer_avalon_master_if.sv
// Avalon-MM bus between timer_avalon_master and the interval timer slave.
//   master modport: drives address/strobes/writedata, receives readdata and irq.
//   slave  modport: the timer side of the same wires.
interface timer_avalon_master_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              irq;

    modport master (
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_readdata, irq
    );

    modport slave (
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_readdata, irq
    );
endinterface

// File: rtl/timer_avalon_master.sv
// Sequencer that drives an Avalon interval timer: start, stop, snapshot and
// timeout service, each as a short fixed sequence of single-cycle bus accesses.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   cfg_period           32-bit period, latched when a start sequence begins
//   cfg_continuous       CONT bit, latched with cfg_period
//   cmd_start/stop/snap  single-cycle command pulses (held as pending flags)
//   busy                 high while a sequence is running
//   snap_valid           one-cycle pulse when snap_value has been updated
//   snap_value           last 32-bit counter snapshot
//   tick, tick_count     pulse and wrapping count per serviced timeout
//   bus                  Avalon master side (address/strobes/data, irq)
module timer_avalon_master #(
    parameter int unsigned TICK_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_continuous,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_snap,
    output logic                  busy,
    output logic                  snap_valid,
    output logic [31:0]           snap_value,
    output logic                  tick,
    output logic [TICK_W-1:0]     tick_count,
    timer_avalon_master_if.master bus
);
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] A_STATUS  = 3'd0;
    localparam logic [ADDR_W-1:0] A_CONTROL = 3'd1;
    localparam logic [ADDR_W-1:0] A_PER_L   = 3'd2;
    localparam logic [ADDR_W-1:0] A_PER_H   = 3'd3;
    localparam logic [ADDR_W-1:0] A_SNAP_L  = 3'd4;
    localparam logic [ADDR_W-1:0] A_SNAP_H  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR_ST, S_STOP_WR, S_WR_PL, S_WR_PH, S_WR_CTRL,
        S_SNAP_WR, S_RD_L, S_RD_H, S_CAP_H
    } state_t;

    state_t            state;
    logic              start_pend, stop_pend, snap_pend;
    logic [DATA_W-1:0] per_hi_q;
    logic              cont_q;

    logic idle_c, go_irq_c, go_stop_c, go_start_c, go_snap_c;

    // Dispatch priority from IDLE: irq, stop, start, snap.
    always_comb begin
        idle_c     = (state == S_IDLE);
        go_irq_c   = idle_c & bus.irq;
        go_stop_c  = idle_c & ~bus.irq & stop_pend;
        go_start_c = idle_c & ~bus.irq & ~stop_pend & start_pend;
        go_snap_c  = idle_c & ~bus.irq & ~stop_pend & ~start_pend & snap_pend;
    end

    // Bus outputs are loaded on the edge entering each state, so the access
    // is presented for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            start_pend       <= 1'b0;
            stop_pend        <= 1'b0;
            snap_pend        <= 1'b0;
            per_hi_q         <= '0;
            cont_q           <= 1'b0;
            busy             <= 1'b0;
            snap_valid       <= 1'b0;
            snap_value       <= '0;
            tick             <= 1'b0;
            tick_count       <= '0;
            bus.m_address    <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            bus.m_writedata  <= '0;
        end else begin
            bus.m_address    <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            bus.m_writedata  <= '0;
            tick             <= 1'b0;
            snap_valid       <= 1'b0;

            // A stop pulse cancels any pending start, including one in the same cycle.
            stop_pend  <= (stop_pend & ~go_stop_c) | cmd_stop;
            start_pend <= ((start_pend & ~go_start_c) | cmd_start) & ~cmd_stop;
            snap_pend  <= (snap_pend & ~go_snap_c) | cmd_snap;

            case (state)
                S_IDLE: begin
                    busy <= 1'b1;
                    if (go_irq_c) begin
                        state            <= S_CLR_ST;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_address    <= A_STATUS;
                        tick             <= 1'b1;
                        tick_count       <= tick_count + TICK_W'(1);
                    end else if (go_stop_c) begin
                        state            <= S_STOP_WR;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_address    <= A_CONTROL;
                        bus.m_writedata  <= 16'h0008;
                    end else if (go_start_c) begin
                        state            <= S_WR_PL;
                        per_hi_q         <= cfg_period[31:16];
                        cont_q           <= cfg_continuous;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_address    <= A_PER_L;
                        bus.m_writedata  <= cfg_period[15:0];
                    end else if (go_snap_c) begin
                        state            <= S_SNAP_WR;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_address    <= A_SNAP_L;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_WR_PL: begin
                    state            <= S_WR_PH;
                    bus.m_chipselect <= 1'b1;
                    bus.m_write_n    <= 1'b0;
                    bus.m_address    <= A_PER_H;
                    bus.m_writedata  <= per_hi_q;
                end
                S_WR_PH: begin
                    state            <= S_WR_CTRL;
                    bus.m_chipselect <= 1'b1;
                    bus.m_write_n    <= 1'b0;
                    bus.m_address    <= A_CONTROL;
                    bus.m_writedata  <= {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
                end
                S_SNAP_WR: begin
                    state            <= S_RD_L;
                    bus.m_chipselect <= 1'b1;
                    bus.m_address    <= A_SNAP_L;
                end
                S_RD_L: begin
                    state            <= S_RD_H;
                    bus.m_chipselect <= 1'b1;
                    bus.m_address    <= A_SNAP_H;
                end
                // Read data trails its read cycle by one, so each half lands a state late.
                S_RD_H: begin
                    state             <= S_CAP_H;
                    snap_value[15:0]  <= bus.m_readdata;
                end
                S_CAP_H: begin
                    state             <= S_IDLE;
                    busy              <= 1'b0;
                    snap_value[31:16] <= bus.m_readdata;
                    snap_valid        <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/timer_avalon_master.md
TIMER_AVALON_MASTER -- requirements
Module: timer_avalon_master

Interface
REQ-001 Parameter TICK_W, default 16: width of the timeout event counter tick_count.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cfg_period, input, 32 bits: timer period, sampled when a start command is accepted.
REQ-005 The block SHALL have port cfg_continuous, input, 1 bit: CONT bit value, sampled with cfg_period.
REQ-006 The block SHALL have ports cmd_start, cmd_stop and cmd_snap, inputs, 1 bit each: single-cycle command pulses.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The block SHALL have port snap_valid, output, 1 bit: one-cycle pulse when snap_value updates.
REQ-009 The block SHALL have port snap_value, output, 32 bits: last captured counter snapshot.
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle pulse per serviced timeout.
REQ-011 The block SHALL have port tick_count, output, TICK_W bits: count of serviced timeouts.
REQ-012 The block SHALL have port m_address, output, 3 bits: timer register address.
REQ-013 The block SHALL have ports m_chipselect and m_write_n, outputs, 1 bit each: bus strobes.
REQ-014 The block SHALL have port m_writedata, output, 16 bits: write data to the timer.
REQ-015 The block SHALL have port m_readdata, input, 16 bits: timer read data, valid exactly 1 cycle after a read cycle, no wait states.
REQ-016 The block SHALL have port irq, input, 1 bit: timer interrupt, level-sensitive.

Function
REQ-017 Timer map: 0 status (write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2/3 period low/high, 4/5 snapshot low/high (write triggers capture).
REQ-018 Each bus access SHALL be one cycle: m_chipselect=1; m_write_n=0 for write, 1 for read; m_chipselect=0 and m_write_n=1 otherwise.
REQ-019 cmd_start, cmd_stop and cmd_snap SHALL set sticky pending flags in any state; a flag clears when its sequence begins.
REQ-020 A cmd_stop pulse SHALL also clear pending start; a simultaneous cmd_start and cmd_stop SHALL leave only stop pending.
REQ-021 In IDLE, dispatch priority SHALL be irq service, then stop, then start, then snap; only one sequence runs at a time.
REQ-022 IRQ sequence SHALL be CLR_ST, a write of 0x0000 to address 0; tick pulses and tick_count increments (wrapping modulo 2^TICK_W) on that cycle; then return to IDLE.
REQ-023 STOP sequence SHALL be STOP_WR, a write of 0x0008 to address 1; then return to IDLE.
REQ-024 START sequence SHALL be WR_PL (cfg_period[15:0] to address 2), then WR_PH (cfg_period[31:16] to address 3), then WR_CTRL (control = {0,1,cfg_continuous,1} to address 1), then IDLE, in consecutive cycles.
REQ-025 cfg_period and cfg_continuous SHALL be latched on entry to WR_PL; later changes do not affect the sequence in flight.
REQ-026 SNAP sequence SHALL be SNAP_WR (write 0x0000 to address 4), then RD_L (read address 4), then RD_H (read address 5; capture m_readdata into snap_value[15:0]), then CAP_H (no access; capture m_readdata into snap_value[31:16]; snap_valid=1), then IDLE.
REQ-027 irq asserting mid-sequence SHALL NOT abort the sequence; it is serviced at the next IDLE dispatch.
REQ-028 Because status clears on the CLR_ST edge, irq SHALL be low in the cycle after CLR_ST; the block SHALL dispatch no duplicate CLR_ST for one timeout.
REQ-029 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-030 Asserting reset_n low at any time, including mid-sequence, SHALL immediately force: state IDLE, pending flags 0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0, snap_valid=0, tick=0, snap_value=0, tick_count=0.

Verification
REQ-031 Start: cfg_period=0x0002_2E97, cfg_continuous=1, pulse cmd_start -> writes addr2=0x2E97, addr3=0x0002, addr1=0x0007 in 3 consecutive cycles; busy high for 3 cycles.
REQ-032 IRQ: irq held high until a status write -> one write of 0x0000 to addr0; tick pulses once; tick_count goes 0->1; no second CLR_ST.
REQ-033 Snapshot: timer model returns 0x1234 at addr4 and 0x0005 at addr5 -> snap_value=0x0005_1234 and a single snap_valid pulse 4 cycles after dispatch.
REQ-034 Collision: cmd_start and cmd_stop in the same cycle with irq high -> CLR_ST, then STOP_WR (0x0008), then no start writes.
REQ-035 Reset mid-START after WR_PL -> outputs return to reset values immediately, and no further bus writes occur after release.
REQ-036 Wrap: TICK_W=4, 16 serviced interrupts -> tick_count returns to 0.
